// File: rtl/debug_scan_pkg.sv
// +------------------------------------------------------------------------+
// | debug_scan_pkg : shared types and constants for the debug scan master  |
// | Rev 1.0                                                                |
// +------------------------------------------------------------------------+
`default_nettype none

package debug_scan_pkg;

   localparam int DEF_DR_WIDTH = 38;
   localparam int DEF_IR_WIDTH = 2;

   localparam logic [1:0] IR_OCIMEM    = 2'b00;
   localparam logic [1:0] IR_TRACE     = 2'b01;
   localparam logic [1:0] IR_BREAK     = 2'b10;
   localparam logic [1:0] IR_TRACECTRL = 2'b11;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_UIR  = 3'd1,
      ST_CDR  = 3'd2,
      ST_SDR  = 3'd3,
      ST_UDR  = 3'd4,
      ST_RTI  = 3'd5,
      ST_RSP  = 3'd6
   } scan_state_e;

endpackage

`default_nettype wire

// File: rtl/debug_scan_master_if.sv
// +------------------------------------------------------------------------+
// | debug_scan_master_if : command/response bus of the debug scan master   |
// | Rev 1.0                                                                |
// +------------------------------------------------------------------------+
`default_nettype none

interface debug_scan_master_if
   import debug_scan_pkg::*;
#(
   parameter int DR_WIDTH = DEF_DR_WIDTH,
   parameter int IR_WIDTH = DEF_IR_WIDTH
) ();

   logic                cmd_valid;
   logic                cmd_ready;
   logic [IR_WIDTH-1:0] cmd_ir;
   logic [DR_WIDTH-1:0] cmd_dr;
   logic                rsp_valid;
   logic                rsp_ready;
   logic [DR_WIDTH-1:0] rsp_dr;
   logic [IR_WIDTH-1:0] rsp_ir_out;

   modport master (
      output cmd_valid, cmd_ir, cmd_dr, rsp_ready,
      input  cmd_ready, rsp_valid, rsp_dr, rsp_ir_out
   );

   modport slave (
      input  cmd_valid, cmd_ir, cmd_dr, rsp_ready,
      output cmd_ready, rsp_valid, rsp_dr, rsp_ir_out
   );

endinterface

`default_nettype wire

// File: rtl/debug_scan_tck_gen.sv
// +------------------------------------------------------------------------+
// | debug_scan_tck_gen : tck half-period counter with period/rise strobes  |
// | Rev 1.0                                                                |
// +------------------------------------------------------------------------+
`default_nettype none

module debug_scan_tck_gen #(
   parameter int TCK_DIV = 1
) (
   input  logic clk,
   input  logic reset_n,
   input  logic en,
   output logic tck,
   output logic period_start,
   output logic rise,
   output logic period_end
);

   localparam int PERIOD = 2 * TCK_DIV;
   localparam int CNT_W  = (PERIOD > 2) ? $clog2(PERIOD) : 1;
   localparam logic [CNT_W-1:0] c_low_last    = CNT_W'(TCK_DIV - 1);
   localparam logic [CNT_W-1:0] c_period_last = CNT_W'(PERIOD - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Counter parks at zero while idle so every scan begins on a period start.
   always_comb begin
      cnt_d = '0;
      if (en && (cnt_q != c_period_last)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tck          = en && (cnt_q > c_low_last);
   assign period_start = en && (cnt_q == '0);
   assign rise         = en && (cnt_q == c_low_last);
   assign period_end   = en && (cnt_q == c_period_last);

endmodule

`default_nettype wire

// File: rtl/debug_scan_master.sv
// +------------------------------------------------------------------------+
// | debug_scan_master : virtual-JTAG scan initiator (UIR,CDR,SDR,UDR,RTI)  |
// | Optional: DEBUG_SCAN_SKIP_IR_EN skips UIR when the IR is unchanged     |
// | Rev 1.0                                                                |
// +------------------------------------------------------------------------+
`default_nettype none

module debug_scan_master
   import debug_scan_pkg::*;
#(
   parameter int DR_WIDTH = DEF_DR_WIDTH,
   parameter int IR_WIDTH = DEF_IR_WIDTH,
   parameter int TCK_DIV  = 1
) (
   input  logic                clk,
   input  logic                reset_n,
   debug_scan_master_if.slave  bus,
   output logic                vji_tck,
   output logic                vji_tdi,
   input  logic                vji_tdo,
   output logic [IR_WIDTH-1:0] vji_ir_in,
   input  logic [IR_WIDTH-1:0] vji_ir_out,
   output logic                vji_uir,
   output logic                vji_cdr,
   output logic                vji_sdr,
   output logic                vji_udr,
   output logic                vji_rti,
   output logic                busy
);

   localparam int BIT_W = (DR_WIDTH > 2) ? $clog2(DR_WIDTH) : 1;
   localparam logic [BIT_W-1:0] c_last_bit = BIT_W'(DR_WIDTH - 1);

   scan_state_e         state_q, state_d;
   logic [IR_WIDTH-1:0] ir_q, ir_d, ir_out_q, ir_out_d;
   logic [DR_WIDTH-1:0] dr_q, dr_d, shift_q, shift_d, cap_q, cap_d;
   logic [BIT_W-1:0]    bit_q, bit_d;
   logic                w_accept, w_skip_uir;
   logic                w_period_start, w_rise, w_period_end;

   // Gated by reset_n so the port reads 0 while reset is held.
   assign bus.cmd_ready = (state_q == ST_IDLE) && reset_n;
   assign w_accept      = bus.cmd_valid && bus.cmd_ready;
   assign busy          = state_q inside {ST_UIR, ST_CDR, ST_SDR, ST_UDR, ST_RTI};

`ifdef DEBUG_SCAN_SKIP_IR_EN
   logic ir_valid_q, ir_valid_d;

   always_comb begin
      ir_valid_d = ir_valid_q | w_accept;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ir_valid_q <= 1'b0;
      end else begin
         ir_valid_q <= ir_valid_d;
      end
   end

   assign w_skip_uir = ir_valid_q && (bus.cmd_ir == ir_q);
`else
   assign w_skip_uir = 1'b0;
`endif

   debug_scan_tck_gen #(
      .TCK_DIV (TCK_DIV)
   ) u_tck_gen (
      .clk          (clk),
      .reset_n      (reset_n),
      .en           (busy),
      .tck          (vji_tck),
      .period_start (w_period_start),
      .rise         (w_rise),
      .period_end   (w_period_end)
   );

   always_comb begin
      state_d  = state_q;
      ir_d     = ir_q;
      ir_out_d = ir_out_q;
      dr_d     = dr_q;
      shift_d  = shift_q;
      cap_d    = cap_q;
      bit_d    = bit_q;
      case (state_q)
         ST_IDLE: begin
            if (w_accept) begin
               ir_d    = bus.cmd_ir;
               dr_d    = bus.cmd_dr;
               state_d = w_skip_uir ? ST_CDR : ST_UIR;
            end
         end
         ST_UIR: begin
            if (w_rise)       ir_out_d = vji_ir_out;
            if (w_period_end) state_d  = ST_CDR;
         end
         ST_CDR: begin
            if (w_period_start) shift_d = dr_q;
            if (w_period_end)   state_d = ST_SDR;
         end
         ST_SDR: begin
            // Capture fills from the MSB; after DR_WIDTH shifts bit k holds period k.
            if (w_rise) cap_d = {vji_tdo, cap_q[DR_WIDTH-1:1]};
            if (w_period_end) begin
               shift_d = shift_q >> 1;
               if (bit_q == c_last_bit) begin
                  bit_d   = '0;
                  state_d = ST_UDR;
               end else begin
                  bit_d = bit_q + BIT_W'(1);
               end
            end
         end
         ST_UDR: begin
            if (w_period_end) state_d = ST_RTI;
         end
         ST_RTI: begin
            if (w_period_end) state_d = ST_RSP;
         end
         ST_RSP: begin
            if (bus.rsp_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= ST_IDLE;
         ir_q     <= '0;
         ir_out_q <= '0;
         dr_q     <= '0;
         shift_q  <= '0;
         cap_q    <= '0;
         bit_q    <= '0;
      end else begin
         state_q  <= state_d;
         ir_q     <= ir_d;
         ir_out_q <= ir_out_d;
         dr_q     <= dr_d;
         shift_q  <= shift_d;
         cap_q    <= cap_d;
         bit_q    <= bit_d;
      end
   end

   assign vji_ir_in      = ir_q;
   assign vji_tdi        = (state_q == ST_SDR) && shift_q[0];
   assign vji_uir        = (state_q == ST_UIR);
   assign vji_cdr        = (state_q == ST_CDR);
   assign vji_sdr        = (state_q == ST_SDR);
   assign vji_udr        = (state_q == ST_UDR);
   assign vji_rti        = (state_q == ST_RTI);
   assign bus.rsp_valid  = (state_q == ST_RSP);
   assign bus.rsp_dr     = cap_q;
   assign bus.rsp_ir_out = ir_out_q;

endmodule

`default_nettype wire

// File: tb/tb_debug_scan_master.sv
// +------------------------------------------------------------------------+
// | tb_debug_scan_master : randomized self-checking bench for the scan     |
// | master (TCK_DIV=1 and TCK_DIV=3 instances). Rev 1.0                    |
// +------------------------------------------------------------------------+
`default_nettype none

module tb_debug_scan_master;
   import debug_scan_pkg::*;

   localparam int DW = 38;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   debug_scan_master_if #(.DR_WIDTH(DW), .IR_WIDTH(2)) bus ();
   debug_scan_master_if #(.DR_WIDTH(DW), .IR_WIDTH(2)) bus3 ();

   logic       vji_tck, vji_tdi, vji_tdo, vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti, busy;
   logic [1:0] vji_ir_in, vji_ir_out;
   logic       vji_tck3, vji_tdi3, vji_uir3, vji_cdr3, vji_sdr3, vji_udr3, vji_rti3, busy3;
   logic [1:0] vji_ir_in3;

   debug_scan_master #(.DR_WIDTH(DW), .IR_WIDTH(2), .TCK_DIV(1)) dut (
      .clk(clk), .reset_n(reset_n), .bus(bus),
      .vji_tck(vji_tck), .vji_tdi(vji_tdi), .vji_tdo(vji_tdo),
      .vji_ir_in(vji_ir_in), .vji_ir_out(vji_ir_out),
      .vji_uir(vji_uir), .vji_cdr(vji_cdr), .vji_sdr(vji_sdr),
      .vji_udr(vji_udr), .vji_rti(vji_rti), .busy(busy)
   );

   debug_scan_master #(.DR_WIDTH(DW), .IR_WIDTH(2), .TCK_DIV(3)) dut3 (
      .clk(clk), .reset_n(reset_n), .bus(bus3),
      .vji_tck(vji_tck3), .vji_tdi(vji_tdi3), .vji_tdo(vji_tdi3),
      .vji_ir_in(vji_ir_in3), .vji_ir_out(2'b10),
      .vji_uir(vji_uir3), .vji_cdr(vji_cdr3), .vji_sdr(vji_sdr3),
      .vji_udr(vji_udr3), .vji_rti(vji_rti3), .busy(busy3)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // Slave-side model: tdo is either looped from tdi or taken from a per-period table.
   int            tdo_mode = 0;
   logic [DW-1:0] tdo_bits = '0;
   int            sdr_cnt  = 0;
   logic [4:0]    flag_log[$];
   logic [1:0]    uir_ir_seen = 2'b00;

   // Reference state for the optional IR-skip behaviour.
   logic [1:0] m_ir = 2'b00;
   bit         m_ir_valid = 1'b0;
   logic [1:0] m_ir_out = 2'b00;

   assign vji_tdo = (tdo_mode == 0) ? vji_tdi : ((sdr_cnt < DW) ? tdo_bits[sdr_cnt] : 1'b0);

   always @(posedge vji_tck) begin
      flag_log.push_back({vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti});
      if (vji_cdr) sdr_cnt = 0;
      if (vji_sdr) sdr_cnt = sdr_cnt + 1;
      if (vji_uir) uir_ir_seen = vji_ir_in;
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] outs_vec();
      return 64'({bus.cmd_ready, bus.rsp_valid, bus.rsp_ir_out, vji_tck, vji_tdi, vji_ir_in,
                  vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti, busy});
   endfunction

   task automatic run_scan(input logic [1:0] ir, input logic [DW-1:0] dr, input int mode,
                           input logic [DW-1:0] bits, input logic [1:0] irout, input int hold);
      bit            skip = 1'b0;
      logic [DW-1:0] exp_dr, held_dr;
      logic [1:0]    exp_ir_out;
      int            lat = 0, base = 0, herr = 0, waitc = 0, ferr = 0, nsdr = 0, exp_len;
      logic          busy_first = 1'b0;
`ifdef DEBUG_SCAN_SKIP_IR_EN
      skip = m_ir_valid && (m_ir == ir);
`endif
      exp_dr     = (mode == 0) ? dr : bits;
      exp_ir_out = skip ? m_ir_out : irout;
      exp_len    = DW + 4 - (skip ? 1 : 0);
      tdo_mode   = mode;
      tdo_bits   = bits;
      vji_ir_out = irout;

      @(negedge clk);
      base = flag_log.size();
      bus.cmd_valid = 1'b1;
      bus.cmd_ir    = ir;
      bus.cmd_dr    = dr;
      while (!bus.cmd_ready && waitc < 20) begin
         @(negedge clk);
         waitc++;
      end
      check("cmd_ready", 64'(bus.cmd_ready), 64'd1);
      @(posedge clk);
      #1;
      bus.cmd_valid = 1'b0;
      do begin
         @(negedge clk);
         lat++;
         if (lat == 1) busy_first = busy;
      end while (!bus.rsp_valid && lat < 2000);

      check("busy_start", 64'(busy_first), 64'd1);
      check("latency", 64'(lat), 64'(1 + exp_len * 2));
      check("rsp_dr", 64'(bus.rsp_dr), 64'(exp_dr));
      check("rsp_ir_out", 64'(bus.rsp_ir_out), 64'(exp_ir_out));
      check("ir_in_hold", 64'(vji_ir_in), 64'(ir));

      if (flag_log.size() - base != exp_len) ferr++;
      for (int i = 0; i < exp_len && (base + i) < flag_log.size(); i++) begin
         int         j;
         logic [4:0] e;
         j = skip ? i + 1 : i;
         if (j == 0)           e = 5'b10000;
         else if (j == 1)      e = 5'b01000;
         else if (j < DW + 2)  e = 5'b00100;
         else if (j == DW + 2) e = 5'b00010;
         else                  e = 5'b00001;
         if (flag_log[base + i] !== e) ferr++;
         if (flag_log[base + i] === 5'b00100) nsdr++;
      end
      check("flag_seq", 64'(ferr), 64'd0);
      check("sdr_periods", 64'(nsdr), 64'(DW));
      if (!skip) check("uir_ir_in", 64'(uir_ir_seen), 64'(ir));

      held_dr = bus.rsp_dr;
      for (int i = 0; i < hold; i++) begin
         if (!bus.rsp_valid || bus.rsp_dr !== held_dr || bus.cmd_ready || busy || vji_tck) herr++;
         bus.cmd_valid = (i == hold / 2);
         bus.cmd_ir    = ~ir;
         bus.cmd_dr    = ~dr;
         @(negedge clk);
      end
      bus.cmd_valid = 1'b0;
      if (hold > 0) check("hold_stable", 64'(herr), 64'd0);
      check("rsp_valid_held", 64'(bus.rsp_valid), 64'd1);
      check("rsp_no_ready", 64'(bus.cmd_ready), 64'd0);

      // A command offered in the handshake cycle itself must be ignored.
      bus.rsp_ready = 1'b1;
      bus.cmd_valid = 1'b1;
      bus.cmd_ir    = ~ir;
      bus.cmd_dr    = ~dr;
      @(posedge clk);
      #1;
      bus.rsp_ready = 1'b0;
      bus.cmd_valid = 1'b0;
      @(negedge clk);
      check("rsp_released", 64'(bus.rsp_valid), 64'd0);
      check("idle_after_rsp", 64'({busy, bus.cmd_ready}), 64'b01);
      @(negedge clk);
      check("no_stray_accept", 64'(busy), 64'd0);

      m_ir       = ir;
      m_ir_valid = 1'b1;
      m_ir_out   = exp_ir_out;
   endtask

   initial begin
      logic [63:0] r1, r2;
      int          waitc, lat, run, rises, rerr;
      logic        prev;

      bus.cmd_valid  = 1'b0; bus.cmd_ir  = '0; bus.cmd_dr  = '0; bus.rsp_ready  = 1'b0;
      bus3.cmd_valid = 1'b0; bus3.cmd_ir = '0; bus3.cmd_dr = '0; bus3.rsp_ready = 1'b0;
      vji_ir_out = 2'b00;
      reset_n    = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_outs", outs_vec(), 64'd0);
      check("reset_rsp_dr", 64'(bus.rsp_dr), 64'd0);
      reset_n = 1'b1;
      @(negedge clk);
      check("idle_ready", 64'(bus.cmd_ready), 64'd1);

      run_scan(IR_BREAK, 38'h2A_5A5A_5A5A, 0, '0, 2'b01, 0);
      r1 = {$urandom, $urandom};
      run_scan(IR_TRACECTRL, r1[DW-1:0], 1, '1, 2'b11, 20);

      for (int i = 0; i < 6; i++) begin
         r1 = {$urandom, $urandom};
         r2 = {$urandom, $urandom};
         run_scan(2'($urandom_range(0, 3)), r1[DW-1:0], int'($urandom_range(0, 1)),
                  r2[DW-1:0], 2'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
      end

      // Abort a scan in the middle of SDR with an asynchronous reset.
      tdo_mode   = 0;
      vji_ir_out = 2'b10;
      r1 = {$urandom, $urandom};
      @(negedge clk);
      bus.cmd_valid = 1'b1;
      bus.cmd_ir    = IR_BREAK;
      bus.cmd_dr    = r1[DW-1:0];
      @(posedge clk);
      #1;
      bus.cmd_valid = 1'b0;
      waitc = 0;
      while (!(vji_sdr && sdr_cnt == 17) && waitc < 500) begin
         @(negedge clk);
         waitc++;
      end
      check("abort_point", 64'(sdr_cnt), 64'd17);
      reset_n = 1'b0;
      #1;
      check("abort_outs", outs_vec(), 64'd0);
      check("abort_rsp_dr", 64'(bus.rsp_dr), 64'd0);
      m_ir = 2'b00; m_ir_valid = 1'b0; m_ir_out = 2'b00;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      run_scan(IR_BREAK, 38'h1, 0, '0, 2'b10, 0);

      r1 = {$urandom, $urandom};
      run_scan(IR_TRACE, r1[DW-1:0], 0, '0, 2'b01, 0);
      r2 = {$urandom, $urandom};
      run_scan(IR_TRACE, r2[DW-1:0], 1, r1[DW-1:0], 2'b10, 0);
      run_scan(IR_OCIMEM, r2[DW-1:0], 0, '0, 2'b11, 0);

      // Slow-clock instance: tck must be 3 clk low / 3 clk high throughout the scan.
      r1 = {$urandom, $urandom};
      @(negedge clk);
      check("tck3_ready", 64'(bus3.cmd_ready), 64'd1);
      bus3.cmd_valid = 1'b1;
      bus3.cmd_ir    = IR_TRACECTRL;
      bus3.cmd_dr    = r1[DW-1:0];
      @(posedge clk);
      #1;
      bus3.cmd_valid = 1'b0;
      lat = 0; run = 0; rises = 0; rerr = 0; prev = 1'b0;
      do begin
         @(negedge clk);
         lat++;
         if (busy3) begin
            if (vji_tck3 == prev) begin
               run++;
            end else begin
               if (run != 3) rerr++;
               if (vji_tck3) rises++;
               prev = vji_tck3;
               run  = 1;
            end
         end
      end while (!bus3.rsp_valid && lat < 3000);
      if (run != 3) rerr++;
      check("tck3_latency", 64'(lat), 64'd253);
      check("tck3_halfperiods", 64'(rerr), 64'd0);
      check("tck3_periods", 64'(rises), 64'(DW + 4));
      check("tck3_rsp_dr", 64'(bus3.rsp_dr), 64'(r1[DW-1:0]));
      check("tck3_rsp_ir_out", 64'(bus3.rsp_ir_out), 64'b10);
      bus3.rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      bus3.rsp_ready = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not reach end of test");
      $fatal(1, "watchdog expired");
   end

endmodule

`default_nettype wire
